// File: rtl/strobe_sync_rx_multi.sv
// strobe_sync_rx_multi
// Receive-side synchroniser for toggle-encoded events crossing into this
// clock domain, replicated per channel. Each level change of toggle_in is
// turned into a one-cycle strobe (with registered fan-out copies), the
// accompanying data word is captured, and a saturating pending count is
// kept until the consumer acknowledges each event.
//
// Ports:
//   clk            consumer-domain clock
//   rst            asynchronous active-high reset
//   toggle_in      per-channel toggle flag from the foreign domain
//   data_in        per-channel data word, stable while its toggle settles
//   ack_in         per-channel acknowledge, one pulse consumes one event
//   clr_ovf        per-channel clear of the sticky overflow flag
//   strobe_out     per-channel one-cycle event strobe
//   strobe_out_dup NUM_DUP copies of strobe_out, copy d of channel c at d*NUM_CH+c
//   data_out       per-channel data captured with the strobe
//   pending        per-channel pending count is non-zero
//   pend_cnt       per-channel pending count
//   overflow       per-channel sticky flag: event arrived at a saturated count
//   ready          high once post-reset settling has completed
module strobe_sync_rx_multi #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int NUM_DUP     = 3,
    parameter int CNT_W       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         toggle_in,
    input  logic [NUM_CH*WIDTH-1:0]   data_in,
    input  logic [NUM_CH-1:0]         ack_in,
    input  logic [NUM_CH-1:0]         clr_ovf,
    output logic [NUM_CH-1:0]         strobe_out,
    output logic [NUM_DUP*NUM_CH-1:0] strobe_out_dup,
    output logic [NUM_CH*WIDTH-1:0]   data_out,
    output logic [NUM_CH-1:0]         pending,
    output logic [NUM_CH*CNT_W-1:0]   pend_cnt,
    output logic [NUM_CH-1:0]         overflow,
    output logic                      ready
);

    localparam int SET_W = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0]    sync_q [NUM_CH];
    logic [NUM_CH-1:0]         prv_q;
    logic [SET_W-1:0]          settle_q;
    logic                      ready_q;
    logic [NUM_CH-1:0]         ev;
    logic [NUM_CH-1:0]         strobe_q;
    logic [NUM_DUP*NUM_CH-1:0] dup_q;
    logic [NUM_CH*WIDTH-1:0]   data_q;
    logic [NUM_CH*CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]         pend_q, pend_d;
    logic [NUM_CH-1:0]         ovf_q, ovf_d;
    logic [CNT_W-1:0]          cur, nxt;
    logic                      ovf_set;

    // Synchroniser chains run even before ready so that a level held
    // through reset is absorbed into prv_q instead of becoming an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sync_q[c] <= '0;
            end
            prv_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], toggle_in[c]};
                prv_q[c]  <= sync_q[c][SYNC_STAGES-1];
            end
        end
    end

    // Settle: ready after SYNC_STAGES+1 cycles out of reset, then sticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_q <= '0;
            ready_q  <= 1'b0;
        end else if (!ready_q) begin
            if (settle_q == SET_W'(SYNC_STAGES)) begin
                ready_q <= 1'b1;
            end else begin
                settle_q <= settle_q + 1'b1;
            end
        end
    end

    // Edge detect, masked until the chains have settled.
    always_comb begin
        ev = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ev[c] = ready_q & (sync_q[c][SYNC_STAGES-1] ^ prv_q[c]);
        end
    end

    // Strobe, its fan-out copies and data capture. Every duplicate is a
    // separate flop fed from ev so that each copy drives its own load
    // group; they are intentionally redundant and must stay distinct.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q <= '0;
            dup_q    <= '0;
            data_q   <= '0;
        end else begin
            strobe_q <= ev;
            for (int d = 0; d < NUM_DUP; d++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    dup_q[d*NUM_CH + c] <= ev[c];
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (ev[c]) begin
                    data_q[c*WIDTH +: WIDTH] <= data_in[c*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Pending counter next state. A strobe together with an ack cancels
    // out, so neither saturation nor underflow applies in that case.
    always_comb begin
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        cur     = '0;
        nxt     = '0;
        ovf_set = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            cur     = cnt_q[c*CNT_W +: CNT_W];
            nxt     = cur;
            ovf_set = 1'b0;
            if (strobe_q[c] && !ack_in[c]) begin
                if (cur == CNT_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    nxt = cur + 1'b1;
                end
            end else if (!strobe_q[c] && ack_in[c] && (cur != '0)) begin
                nxt = cur - 1'b1;
            end
            cnt_d[c*CNT_W +: CNT_W] = nxt;
            pend_d[c] = (nxt != '0);
            // Set wins over a simultaneous clear.
            ovf_d[c]  = ovf_set | (ovf_q[c] & ~clr_ovf[c]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign strobe_out     = strobe_q;
    assign strobe_out_dup = dup_q;
    assign data_out       = data_q;
    assign pending        = pend_q;
    assign pend_cnt       = cnt_q;
    assign overflow       = ovf_q;
    assign ready          = ready_q;

endmodule

// File: doc/strobe_sync_rx_multi.md
Name: strobe_sync_rx_multi

Overview:
- Multi-channel receive-side event synchroniser for toggle-encoded strobes arriving asynchronously from another clock domain.
- Each channel:
  - runs a parametrised synchroniser chain on its toggle flag;
  - converts each toggle transition into a one-cycle strobe, with registered fan-out duplicates;
  - captures the qualified data word;
  - keeps a saturating pending-event count that the consumer drains with an acknowledge.
- Sits in the consumer domain, replacing single-channel strobe crossers in bridges such as the USB-to-serial path.

Parameters:
- NUM_CH, 4, number of independent channels.
- WIDTH, 8, data bits per channel.
- SYNC_STAGES, 2, synchroniser flops per channel (minimum 2).
- NUM_DUP, 3, registered duplicate copies of each strobe for fan-out.
- CNT_W, 4, width of each per-channel pending counter.

Ports:
- clk  input  1  single clock; all logic rises on its positive edge.
- rst  input  1  asynchronous, active-high reset.
- toggle_in  input  NUM_CH  per-channel toggle flag from the foreign domain; each level change is one event.
- data_in  input  NUM_CH*WIDTH  per-channel data; sender holds it stable from the toggle until the next toggle.
- ack_in  input  NUM_CH  consumer acknowledge; one pulse consumes one pending event.
- clr_ovf  input  NUM_CH  clears the sticky overflow flag.
- strobe_out  output  NUM_CH  one-cycle event strobe.
- strobe_out_dup  output  NUM_DUP*NUM_CH  registered copies of strobe_out; copy d of channel c is at bit d*NUM_CH+c.
- data_out  output  NUM_CH*WIDTH  data captured with the strobe.
- pending  output  NUM_CH  pending count is non-zero.
- pend_cnt  output  NUM_CH*CNT_W  per-channel pending count.
- overflow  output  NUM_CH  sticky; set when an event arrives at a saturated count.
- ready  output  1  high once post-reset settling has completed.

Behaviour:
- Reset (asynchronous) zeroes:
  - synchroniser chains, previous-sample flops and the settle counter;
  - strobe_out, strobe_out_dup and data_out;
  - pend_cnt, pending, overflow and ready.
- Synchroniser: each channel has a chain sync[0..SYNC_STAGES-1] plus a previous-sample flop prv.
  - Per clock: sync shifts in toggle_in; prv takes sync[SYNC_STAGES-1].
  - Edge term: ev = sync[SYNC_STAGES-1] ^ prv.
- Settle: after rst deasserts, a counter runs for SYNC_STAGES+1 cycles, then ready goes high and stays high.
  - While ready=0, ev is masked: no strobe, no capture, no count change.
  - The chains still run, so a toggle_in held at 1 through reset produces no spurious event.
- Strobe latency: take the first clock edge that samples a new toggle_in level as edge 1.
  - strobe_out rises at edge SYNC_STAGES+1 and is high for exactly one cycle.
  - strobe_out_dup copies are registered in parallel with strobe_out and are bit-identical every cycle.
  - Each copy is its own flop and must not be merged by synthesis.
- Data capture: on the edge that raises strobe_out, data_out takes that channel's data_in. Otherwise data_out holds.
- Back-to-back events: toggles spaced one clock apart give strobes on consecutive cycles. No events are lost in the synchroniser.
- Pending counter, per channel, per clock (strobe = the registered strobe_out):
  - strobe only, count < max: count+1.
  - strobe only, count == max (2^CNT_W-1): count held; overflow set.
  - ack_in only, count > 0: count-1.
  - ack_in only, count == 0: ignored; no underflow and no flag.
  - strobe and ack_in in the same cycle: count unchanged, including at max (no overflow) and at 0.
- pending: registered equivalent of pend_cnt != 0, updated in the same cycle as pend_cnt.
- Overflow flag:
  - Stays set until a clr_ovf pulse.
  - If clr_ovf and a new overflow event occur in the same cycle, the flag stays set (set wins).
- Channels are fully independent; activity on one never affects another.
- Reset mid-operation: all state clears immediately, in-flight toggles are discarded, and the settle sequence restarts.

Test Plan:
- SYNC_STAGES=2, ready high; toggle_in[0] 0→1 with data_in[0]=0xA5 -> strobe_out[0] high for one cycle at edge 3; data_out[0]=0xA5 on the same edge; pend_cnt[0]=1; all 3 dup copies equal strobe_out.
- toggle_in=4'b1111 held through reset release -> ready rises after 3 cycles; no strobe on any channel; pend_cnt all 0.
- Channel 1: toggle 15 times with no ack, then once more -> pend_cnt[1]=15, overflow[1]=1; clr_ovf[1] pulse -> overflow[1]=0 and count stays 15.
- Channel 2: strobe coincides with ack_in at count 3 -> count stays 3. At count 0, ack_in alone -> count stays 0 with no flag.
- Channel 3: toggle every cycle for 4 cycles -> 4 consecutive strobes; pend_cnt[3]=4; channels 0–2 unchanged.
- Assert rst while an event is mid-synchroniser -> outputs 0 immediately; no strobe after release; ready reasserts after SYNC_STAGES+1 cycles.
